dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares the single data memory between the single-cycle core's load/store port and a DMA/debug requester.
// - Sits between single_cycle_core (alu_result/write_data/mem_write) and data_memory.
// - Core gets combinational read data and a stall; the DMA side uses a valid/ready handshake with registered read return.
// - Bounded DMA bursts guarantee core forward progress.
// PARAMETERS
// - ADDR_W     32  address width, both requesters and memory
// - DATA_W     32  data width
// - MAX_BURST  8   max cycles DMA may hold the bus in one burst (>=2); CNT_W = $clog2(MAX_BURST)
// PORTS
// - clk          in   1       clock; all state updates on rising edge
// - reset        in   1       asynchronous, active-low (0 = reset)
// - core_req     in   1       core load or store this cycle
// - core_we      in   1       core store (valid with core_req)
// - core_addr    in   ADDR_W  core address (alu_result)
// - core_wdata   in   DATA_W  core store data
// - core_rdata   out  DATA_W  = mem_rdata, combinational
// - core_stall   out  1       core_req && !core_gnt; core holds PC, suppresses regfile write
// - dma_valid    in   1       DMA beat request
// - dma_we       in   1       DMA write beat
// - dma_last     in   1       final beat of DMA burst
// - dma_addr     in   ADDR_W  DMA address
// - dma_wdata    in   DATA_W  DMA write data
// - dma_ready    out  1       dma_gnt; beat accepted when dma_valid && dma_ready
// - dma_rdata    out  DATA_W  registered read data
// - dma_rvalid   out  1       1-cycle pulse, cycle after an accepted read beat
// - mem_we       out  1       to data_memory write_enable
// - mem_addr     out  ADDR_W  to data_memory address
// - mem_wdata    out  DATA_W  to data_memory write_data
// - mem_rdata    in   DATA_W  from data_memory read_data (combinational)
// BEHAVIOUR
// - State: st in {ARB, BURST}, last_gnt (0=core, 1=DMA), cnt[CNT_W-1:0].
// - Reset (reset=0): st=ARB, last_gnt=1 (core wins first tie), cnt=0, dma_rvalid=0, dma_rdata=0.
//   Combinationally while reset=0: mem_we=0, dma_ready=0, core_stall=0.
// - Grant (combinational, at most one of core_gnt/dma_gnt):
//   ARB, only core_req -> core_gnt. ARB, only dma_valid -> dma_gnt.
//   ARB, both -> core_gnt if last_gnt=1, else dma_gnt. BURST -> dma_gnt = dma_valid, core_gnt = 0.
// - Mux: core_gnt -> mem_* = core_*, mem_we = core_we. dma_gnt -> mem_* = dma_*, mem_we = dma_we.
//   Neither -> mem_we=0; addr/wdata hold core values.
// - last_gnt <= 1 on any dma_gnt, <= 0 on core_gnt, else holds.
// - Transitions:
//   ARB -> BURST on accepted DMA beat with dma_last=0; cnt <= 1.
//   BURST counts cycles, idle cycles included: cnt <= cnt+1.
//   BURST -> ARB on accepted beat with dma_last=1, or when cnt == MAX_BURST-1
//   (forced release; this cycle's beat, if any, still accepted); cnt <= 0.
//   After forced release last_gnt=1, so a waiting core wins the next cycle.
//   DMA continues arbitrating from ARB.
// - Core stall bound: a core request waits at most MAX_BURST+1 cycles.
// - Writes take effect at the clock edge of the granted cycle (data_memory sync write).
//   Reads return same cycle to core; registered one cycle later to DMA.
// - dma_rdata updates only on accepted read beats; it holds otherwise.
// - Reset mid-burst: burst abandoned, st=ARB; no partial write (mem_we forced 0 while reset=0).
// - Same address, core and DMA in one cycle: only the granted side accesses; no merging.
// TESTING
// - Reset then core_req=1, we=1, addr=0x10, wdata=0xDEADBEEF, dma idle -> mem_we=1, core_stall=0, mem[0x10]=0xDEADBEEF.
// - Core_req and dma_valid both high, 4 single-beat (last=1) requests -> grants alternate core, DMA, core, DMA.
//   core_stall=1 exactly on DMA cycles.
// - DMA read beat addr=0x10, last=1 -> dma_ready=1, next cycle dma_rvalid=1, dma_rdata=0xDEADBEEF, then rvalid=0.
// - DMA burst, 12 beats, last only on beat 12, core_req held, MAX_BURST=8 ->
//   DMA owns 8 cycles, core granted cycle 9, DMA resumes.
// - Burst with dma_valid dropped 3 cycles mid-burst -> core stays stalled; forced release still after 8 cycles total.
// - reset pulled low mid-burst during a write beat -> mem_we=0 immediately, dma_rvalid=0; after release, st=ARB and core wins first tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core load/store port and a DMA/debug requester.
// The core wins ties after a DMA grant; DMA bursts are cut after MAX_BURST cycles so the core always progresses.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_stall_o,
    input  logic              dma_valid_i,
    input  logic              dma_we_i,
    input  logic              dma_last_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_ready_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_rvalid_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {ST_ARB, ST_BURST} state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic core_gnt, dma_gnt, dma_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ARB;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign dma_acc = dma_gnt && dma_valid_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        rvalid_d   = dma_acc && !dma_we_i;
        rdata_d    = (dma_acc && !dma_we_i) ? mem_rdata_i : rdata_q;
        if (dma_gnt) begin
            last_gnt_d = 1'b1;
        end else if (core_gnt) begin
            last_gnt_d = 1'b0;
        end
        case (state_q)
            ST_ARB: begin
                if (dma_acc && !dma_last_i) begin
                    state_d = ST_BURST;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_BURST: begin
                // idle cycles count too, so a stalled DMA cannot starve the core
                if ((dma_acc && dma_last_i) || cnt_q == CNT_LAST) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (rst_ni) begin
            if (state_q == ST_BURST) begin
                dma_gnt = dma_valid_i;
            end else if (core_req_i && dma_valid_i) begin
                core_gnt = last_gnt_q;
                dma_gnt  = !last_gnt_q;
            end else begin
                core_gnt = core_req_i;
                dma_gnt  = dma_valid_i;
            end
        end
        if (dma_gnt) begin
            mem_we_o    = dma_we_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
        end else begin
            mem_we_o    = core_gnt && core_we_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end
        core_rdata_o = mem_rdata_i;
        core_stall_o = rst_ni && core_req_i && !core_gnt;
        dma_ready_o  = dma_gnt;
        dma_rdata_o  = rdata_q;
        dma_rvalid_o = rvalid_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, DMA read-return scoreboard, per-scenario tasks.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dma_valid, dma_we, dma_last;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ready, dma_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_rdata_o(core_rdata), .core_stall_o(core_stall),
        .dma_valid_i(dma_valid), .dma_we_i(dma_we), .dma_last_i(dma_last),
        .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata), .dma_ready_o(dma_ready),
        .dma_rdata_o(dma_rdata), .dma_rvalid_o(dma_rvalid),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    // DMA read returns are matched in order against what was accepted
    always @(negedge clk) begin
        if (rst_n && dma_rvalid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_rvalid got=%h wanted=none", dma_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dma_rdata !== e) begin
                    bad++;
                    $display("FAIL sb_rdata got=%h wanted=%h", dma_rdata, e);
                end
            end
        end
    end

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 32'h10; core_wdata = 0;
        dma_valid = 0; dma_we = 0; dma_last = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        core_req = 1; core_we = 1; dma_valid = 1; dma_we = 1;
        @(negedge clk);
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b wanted=0", mem_we); end
        total++; if (dma_ready !== 1'b0) begin bad++; $display("FAIL rst_dma_ready got=%b wanted=0", dma_ready); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL rst_core_stall got=%b wanted=0", core_stall); end
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b wanted=0", dma_rvalid); end
        total++; if (dma_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h wanted=0", dma_rdata); end
        next_cycle();
        idle();
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_core_write();
        core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL cw_mem_we got=%b wanted=1", mem_we); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL cw_stall got=%b wanted=0", core_stall); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL cw_addr got=%h wanted=10", mem_addr); end
        next_cycle();
        idle();
        total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL cw_mem got=%h wanted=deadbeef", mem[4]); end
    endtask

    task automatic test_dma_read();
        dma_valid = 1; dma_we = 0; dma_last = 1; dma_addr = 32'h10;
        @(negedge clk);
        total++; if (dma_ready !== 1'b1) begin bad++; $display("FAIL dr_ready got=%b wanted=1", dma_ready); end
        if (dma_ready) exp_q.push_back(32'hDEADBEEF);
        next_cycle();
        idle();
        total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL dr_rvalid got=%b wanted=1", dma_rvalid); end
        total++; if (dma_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dr_rdata got=%h wanted=deadbeef", dma_rdata); end
        next_cycle();
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL dr_rvalid_drop got=%b wanted=0", dma_rvalid); end
        total++; if (dma_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dr_rdata_hold got=%h wanted=deadbeef", dma_rdata); end
    endtask

    task automatic test_alternate();
        int k;
        logic exp_dma;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            core_req = 1; core_we = 0; core_addr = 32'h10;
            dma_valid = 1; dma_we = 1; dma_last = 1;
            dma_addr = 32'h40 + 32'(k * 4); dma_wdata = 32'h5A5A0000 + 32'(k);
            @(negedge clk);
            exp_dma = (i % 2) == 1;
            total++; if (dma_ready !== exp_dma) begin bad++; $display("FAIL alt_ready[%0d] got=%b wanted=%b", i, dma_ready, exp_dma); end
            total++; if (core_stall !== exp_dma) begin bad++; $display("FAIL alt_stall[%0d] got=%b wanted=%b", i, core_stall, exp_dma); end
            if (!exp_dma) begin
                total++; if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL alt_core_rdata[%0d] got=%h wanted=deadbeef", i, core_rdata); end
            end
            if (dma_ready) k++;
            next_cycle();
        end
        idle();
        total++; if (mem[16] !== 32'h5A5A0000) begin bad++; $display("FAIL alt_mem0 got=%h wanted=5a5a0000", mem[16]); end
        total++; if (mem[17] !== 32'h5A5A0001) begin bad++; $display("FAIL alt_mem1 got=%h wanted=5a5a0001", mem[17]); end
    endtask

    task automatic test_burst();
        int c, beat;
        logic exp_dma, exp_stall;
        c = 0; beat = 0;
        while (beat < 12 && c < 20) begin
            c++;
            core_req = (c >= 2); core_we = 0; core_addr = 32'h10;
            dma_valid = 1; dma_we = 0; dma_last = (beat == 11);
            dma_addr = 32'h80 + 32'(beat * 4);
            @(negedge clk);
            exp_dma   = (c <= 8) || (c >= 10);
            exp_stall = (c >= 2) && (c != 9);
            total++; if (dma_ready !== exp_dma) begin bad++; $display("FAIL burst_ready[c%0d] got=%b wanted=%b", c, dma_ready, exp_dma); end
            total++; if (core_stall !== exp_stall) begin bad++; $display("FAIL burst_stall[c%0d] got=%b wanted=%b", c, core_stall, exp_stall); end
            if (dma_ready) begin
                exp_q.push_back(32'hA5000020 + 32'(beat));
                beat++;
            end
            next_cycle();
        end
        idle();
        total++; if (c !== 13) begin bad++; $display("FAIL burst_cycles got=%0d wanted=13", c); end
        next_cycle();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL burst_sb_left got=%0d wanted=0", exp_q.size()); end
    endtask

    task automatic test_dropped();
        int beat;
        logic exp_dma, exp_stall;
        beat = 0;
        for (int c = 1; c <= 10; c++) begin
            core_req = (c >= 2); core_we = 0; core_addr = 32'h10;
            dma_valid = !(c >= 3 && c <= 5); dma_we = 0; dma_last = (c == 10);
            dma_addr = 32'h80 + 32'(beat * 4);
            @(negedge clk);
            exp_dma   = (c <= 2) || (c >= 6 && c <= 8) || (c == 10);
            exp_stall = (c >= 2) && (c != 9);
            total++; if (dma_ready !== exp_dma) begin bad++; $display("FAIL drop_ready[c%0d] got=%b wanted=%b", c, dma_ready, exp_dma); end
            total++; if (core_stall !== exp_stall) begin bad++; $display("FAIL drop_stall[c%0d] got=%b wanted=%b", c, core_stall, exp_stall); end
            if (dma_ready && dma_valid) begin
                exp_q.push_back(32'hA5000020 + 32'(beat));
                beat++;
            end
            next_cycle();
        end
        idle();
        next_cycle();
        total++; if (beat !== 6) begin bad++; $display("FAIL drop_beats got=%0d wanted=6", beat); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL drop_sb_left got=%0d wanted=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        dma_valid = 1; dma_we = 0; dma_last = 0; dma_addr = 32'h80;
        @(negedge clk);
        total++; if (dma_ready !== 1'b1) begin bad++; $display("FAIL rmb_first_ready got=%b wanted=1", dma_ready); end
        next_cycle();
        total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL rmb_rvalid got=%b wanted=1", dma_rvalid); end
        total++; if (dma_rdata !== 32'hA5000020) begin bad++; $display("FAIL rmb_rdata got=%h wanted=a5000020", dma_rdata); end
        core_req = 1; core_we = 0;
        dma_valid = 1; dma_we = 1; dma_last = 0; dma_addr = 32'hC4; dma_wdata = 32'h12345678;
        rst_n = 0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmb_mem_we got=%b wanted=0", mem_we); end
        total++; if (dma_ready !== 1'b0) begin bad++; $display("FAIL rmb_ready got=%b wanted=0", dma_ready); end
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rmb_rvalid_clr got=%b wanted=0", dma_rvalid); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL rmb_stall got=%b wanted=0", core_stall); end
        next_cycle();
        next_cycle();
        total++; if (mem[49] !== 32'hA5000031) begin bad++; $display("FAIL rmb_no_write got=%h wanted=a5000031", mem[49]); end
        dma_last = 1;
        rst_n = 1;
        @(negedge clk);
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL rmb_tie_core got=%b wanted=0", core_stall); end
        total++; if (dma_ready !== 1'b0) begin bad++; $display("FAIL rmb_tie_dma got=%b wanted=0", dma_ready); end
        next_cycle();
        @(negedge clk);
        total++; if (dma_ready !== 1'b1) begin bad++; $display("FAIL rmb_next_dma got=%b wanted=1", dma_ready); end
        total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL rmb_next_stall got=%b wanted=1", core_stall); end
        next_cycle();
        idle();
        total++; if (mem[49] !== 32'h12345678) begin bad++; $display("FAIL rmb_late_write got=%h wanted=12345678", mem[49]); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 + 32'(i);
        rst_n = 0;
        idle();
        #1;
        test_reset();
        test_core_write();
        test_dma_read();
        test_alternate();
        test_burst();
        test_dropped();
        test_reset_mid_burst();
        next_cycle();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL final_sb_left got=%0d wanted=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
